// File: rtl/mesync_pkg.sv
// rtl/mesync_pkg.sv - shared mode encodings and sizing helper for the multi-channel edge detector
package mesync_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Counter must hold 0..FILT_LEN; keep at least one bit so a bypassed filter still has a legal width.
  function automatic int filt_cnt_w(input int filt_len);
    if (filt_len < 1) begin
      return 1;
    end
    return $clog2(filt_len + 1);
  endfunction

  function automatic logic mode_takes_rise(input logic [1:0] m);
    return (m == MODE_RISE) || (m == MODE_BOTH);
  endfunction

  function automatic logic mode_takes_fall(input logic [1:0] m);
    return (m == MODE_FALL) || (m == MODE_BOTH);
  endfunction

endpackage

// File: rtl/sync_filt_chan.sv
// rtl/sync_filt_chan.sv - one channel: synchroniser, stability filter, edge qualify, pending/overflow flags
module sync_filt_chan
  import mesync_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_LEN    = 0,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic       clk_fast,
  input  logic       rst,
  input  logic       data_in,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       level,
  output logic       edge_pulse,
  output logic       pending,
  output logic       overflow
);

  localparam int CW = filt_cnt_w(FILT_LEN);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_last;
  logic                   level_q, level_d;
  logic                   edge_pulse_q, edge_pulse_d;
  logic                   pending_q, pending_d;
  logic                   overflow_q, overflow_d;
  logic                   rise, fall;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], data_in};
  end

  assign s_last = sync_q[SYNC_STAGES-1];

  generate
    if (FILT_LEN == 0) begin : g_bypass
      assign level_d = s_last;
    end else begin : g_filter
      localparam logic [CW-1:0] FILT_MAX = CW'(FILT_LEN);
      logic [CW-1:0] cnt_q, cnt_d;
      logic          lvl_d;

      // Level only moves once the mismatch has been seen FILT_LEN+1 times in a row.
      always_comb begin
        cnt_d = '0;
        lvl_d = level_q;
        if (s_last != level_q) begin
          if (cnt_q == FILT_MAX) begin
            lvl_d = s_last;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign level_d = lvl_d;
    end
  endgenerate

  always_comb begin
    rise         = level_d & ~level_q;
    fall         = ~level_d & level_q;
    edge_pulse_d = (rise & mode_takes_rise(mode)) | (fall & mode_takes_fall(mode));

    pending_d = pending_q;
    if (clr) begin
      pending_d = 1'b0;
    end
    if (edge_pulse_d) begin
      pending_d = 1'b1;
    end

    // A clear arriving with the colliding edge wins over overflow but not over pending.
    overflow_d = overflow_q;
    if (clr) begin
      overflow_d = 1'b0;
    end else if (edge_pulse_d && pending_q) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      sync_q       <= {SYNC_STAGES{RST_VAL}};
      level_q      <= RST_VAL;
      edge_pulse_q <= 1'b0;
      pending_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      level_q      <= level_d;
      edge_pulse_q <= edge_pulse_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
    end
  end

  assign level      = level_q;
  assign edge_pulse = edge_pulse_q;
  assign pending    = pending_q;
  assign overflow   = overflow_q;

endmodule

// File: rtl/multi_edge_detect_sync.sv
// rtl/multi_edge_detect_sync.sv - CH independent synchronised edge detectors with pending summary
module multi_edge_detect_sync
  import mesync_pkg::*;
#(
  parameter int   CH          = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_LEN    = 0,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic            clk_fast,
  input  logic            rst,
  input  logic [CH-1:0]   data_in,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0]   clr,
  output logic [CH-1:0]   level,
  output logic [CH-1:0]   edge_pulse,
  output logic [CH-1:0]   pending,
  output logic [CH-1:0]   overflow,
  output logic            any_pending
);

  generate
    for (genvar i = 0; i < CH; i++) begin : g_chan
      sync_filt_chan #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN),
        .RST_VAL    (RST_VAL)
      ) u_chan (
        .clk_fast  (clk_fast),
        .rst       (rst),
        .data_in   (data_in[i]),
        .mode      (mode[2*i +: 2]),
        .clr       (clr[i]),
        .level     (level[i]),
        .edge_pulse(edge_pulse[i]),
        .pending   (pending[i]),
        .overflow  (overflow[i])
      );
    end
  endgenerate

  assign any_pending = |pending;

endmodule

// File: tb/tb_multi_edge_detect_sync.sv
// tb/tb_multi_edge_detect_sync.sv - directed self-checking bench for multi_edge_detect_sync
module tb_multi_edge_detect_sync;

  logic       clk_fast = 1'b0;
  logic       rst_a, rst_b;
  logic [3:0] data_a, data_b, clr_a, clr_b;
  logic [7:0] mode_a, mode_b;
  logic [3:0] level_a, pulse_a, pend_a, ovf_a;
  logic [3:0] level_b, pulse_b, pend_b, ovf_b;
  logic       anyp_a, anyp_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_fast = ~clk_fast;

  multi_edge_detect_sync #(.CH(4), .SYNC_STAGES(2), .FILT_LEN(0), .RST_VAL(1'b0)) dut_a (
    .clk_fast(clk_fast), .rst(rst_a), .data_in(data_a), .mode(mode_a), .clr(clr_a),
    .level(level_a), .edge_pulse(pulse_a), .pending(pend_a), .overflow(ovf_a),
    .any_pending(anyp_a)
  );

  multi_edge_detect_sync #(.CH(4), .SYNC_STAGES(2), .FILT_LEN(3), .RST_VAL(1'b0)) dut_b (
    .clk_fast(clk_fast), .rst(rst_b), .data_in(data_b), .mode(mode_b), .clr(clr_b),
    .level(level_b), .edge_pulse(pulse_b), .pending(pend_b), .overflow(ovf_b),
    .any_pending(anyp_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_fast);
      #1;
    end
  endtask

  logic [3:0] acc;

  initial begin
    rst_a  = 1'b1; rst_b  = 1'b1;
    data_a = '0;   data_b = '0;
    clr_a  = '0;   clr_b  = '0;
    mode_a = 8'b01_11_01_01;
    mode_b = 8'b01_01_01_01;
    tick(2);
    chk("rst_level", {28'd0, level_a}, 32'h0);
    chk("rst_pulse", {28'd0, pulse_a}, 32'h0);
    chk("rst_pend",  {28'd0, pend_a},  32'h0);
    chk("rst_ovf",   {28'd0, ovf_a},   32'h0);
    chk("rst_anyp",  {31'd0, anyp_a},  32'h0);
    rst_a = 1'b0; rst_b = 1'b0;

    acc = '0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      acc |= pulse_a;
    end
    chk("idle_pulse", {28'd0, acc}, 32'h0);
    chk("idle_level", {28'd0, level_a}, 32'h0);

    // ch0 rising edge with two-flop sync and no filter
    data_a[0] = 1'b1;
    tick(1);
    chk("ch0_e0_level", {31'd0, level_a[0]}, 32'h0);
    tick(1);
    chk("ch0_e1_level", {31'd0, level_a[0]}, 32'h0);
    tick(1);
    chk("ch0_e2_level", {31'd0, level_a[0]}, 32'h1);
    chk("ch0_e2_pulse", {31'd0, pulse_a[0]}, 32'h1);
    chk("ch0_e2_pend",  {31'd0, pend_a[0]},  32'h1);
    chk("ch0_e2_anyp",  {31'd0, anyp_a},     32'h1);
    tick(1);
    chk("ch0_e3_pulse", {31'd0, pulse_a[0]}, 32'h0);
    chk("ch0_e3_pend",  {31'd0, pend_a[0]},  32'h1);

    // ch2 both-edges toggle -> overflow, then clear
    data_a[2] = 1'b1;
    tick(3);
    chk("ch2_rise_pulse", {31'd0, pulse_a[2]}, 32'h1);
    tick(7);
    data_a[2] = 1'b0;
    tick(3);
    chk("ch2_fall_pulse", {31'd0, pulse_a[2]}, 32'h1);
    chk("ch2_fall_level", {31'd0, level_a[2]}, 32'h0);
    chk("ch2_pend",       {31'd0, pend_a[2]},  32'h1);
    chk("ch2_ovf",        {31'd0, ovf_a[2]},   32'h1);
    clr_a[2] = 1'b1;
    tick(1);
    clr_a[2] = 1'b0;
    chk("ch2_clr_pend", {31'd0, pend_a[2]}, 32'h0);
    chk("ch2_clr_ovf",  {31'd0, ovf_a[2]},  32'h0);

    // ch3 clear coincident with a qualifying edge while pending
    data_a[3] = 1'b1;
    tick(3);
    chk("ch3_first_pend", {31'd0, pend_a[3]}, 32'h1);
    mode_a[7:6] = 2'b10;
    data_a[3] = 1'b0;
    tick(2);
    clr_a[3] = 1'b1;
    tick(1);
    clr_a[3] = 1'b0;
    chk("ch3_coin_pulse", {31'd0, pulse_a[3]}, 32'h1);
    chk("ch3_coin_pend",  {31'd0, pend_a[3]},  32'h1);
    chk("ch3_coin_ovf",   {31'd0, ovf_a[3]},   32'h0);

    // ch1 mode off: level tracks but nothing is flagged
    mode_a[3:2] = 2'b00;
    data_a[1] = 1'b1;
    tick(3);
    chk("ch1_off_level", {31'd0, level_a[1]}, 32'h1);
    chk("ch1_off_pulse", {31'd0, pulse_a[1]}, 32'h0);
    chk("ch1_off_pend",  {31'd0, pend_a[1]},  32'h0);

    // ch0 rise-only: fall ignored, next rise while pending overflows
    data_a[0] = 1'b0;
    tick(3);
    chk("ch0_fall_level", {31'd0, level_a[0]}, 32'h0);
    chk("ch0_fall_pulse", {31'd0, pulse_a[0]}, 32'h0);
    data_a[0] = 1'b1;
    tick(3);
    chk("ch0_rise2_pulse", {31'd0, pulse_a[0]}, 32'h1);
    chk("ch0_rise2_ovf",   {31'd0, ovf_a[0]},   32'h1);
    clr_a = 4'hF;
    tick(1);
    clr_a = 4'h0;
    chk("clr_all_anyp", {31'd0, anyp_a}, 32'h0);
    chk("clr_all_ovf",  {28'd0, ovf_a},  32'h0);

    // filtered instance: short glitch is swallowed
    acc = '0;
    data_b[1] = 1'b1;
    tick(1); acc |= level_b | pulse_b;
    tick(1); acc |= level_b | pulse_b;
    data_b[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      acc |= level_b | pulse_b;
    end
    chk("glitch_none", {28'd0, acc}, 32'h0);

    // six-cycle pulse passes, level rises at edge 2+3
    data_b[1] = 1'b1;
    tick(5);
    chk("filt_e4_level", {31'd0, level_b[1]}, 32'h0);
    tick(1);
    chk("filt_e5_level", {31'd0, level_b[1]}, 32'h1);
    chk("filt_e5_pulse", {31'd0, pulse_b[1]}, 32'h1);
    chk("filt_e5_pend",  {31'd0, pend_b[1]},  32'h1);
    data_b[1] = 1'b0;

    // reset with ch0 counter at 2, then restart from scratch
    data_b[0] = 1'b1;
    tick(4);
    chk("midfilt_level", {31'd0, level_b[0]}, 32'h0);
    rst_b = 1'b1;
    #2;
    chk("async_rst_pend",  {28'd0, pend_b},  32'h0);
    chk("async_rst_level", {28'd0, level_b}, 32'h0);
    @(posedge clk_fast);
    #1;
    rst_b = 1'b0;
    tick(4);
    chk("post_rst_e3_level", {31'd0, level_b[0]}, 32'h0);
    tick(1);
    chk("post_rst_e4_level", {31'd0, level_b[0]}, 32'h0);
    tick(1);
    chk("post_rst_e5_level", {31'd0, level_b[0]}, 32'h1);
    chk("post_rst_e5_pulse", {31'd0, pulse_b[0]}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_edge_detect_sync.md
Name: multi_edge_detect_sync

Overview:
Parametrised, multi-channel successor to the single-bit synchroniser/edge detector. It brings CH asynchronous single-bit inputs into the clk_fast domain through a configurable N-flop synchroniser. It optionally deglitches each channel with a stability filter and detects rising, falling or both edges per channel under runtime mode control. Each detected edge is reported as a one-cycle pulse and as a sticky pending flag, with overflow tracking, for a downstream controller to service.

Parameters:
CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILT_LEN, 0, consecutive stable cycles required before the filtered level changes; 0 = filter bypass
RST_VAL, 1'b0, reset value of synchroniser flops and filtered level (all channels)

Ports:
clk_fast  in   1       sole clock; all state on rising edge
rst       in   1       asynchronous, active-high reset
data_in   in   CH      asynchronous inputs, one per channel
mode      in   2*CH    per-channel edge select, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
clr       in   CH      per-channel clear of pending/overflow (clk_fast-synchronous)
level     out  CH      filtered, synchronised level
edge_pulse out CH      one-cycle pulse per qualifying edge
pending   out  CH      sticky edge flag
overflow  out  CH      sticky: edge arrived while pending already set
any_pending out 1      OR-reduction of pending (combinational)

Behaviour:
- Reset (async assert, sync release by system): sync flops = RST_VAL, level = RST_VAL, filter counters = 0, edge_pulse/pending/overflow = 0.
- No pulse after reset release when data_in == RST_VAL.
- Sync chain: s[0] <= data_in[i]; s[k] <= s[k-1]; s_last = s[SYNC_STAGES-1]. Only s_last feeds further logic.
- Filter, per channel: counter width $clog2(FILT_LEN+1).
  - s_last == level -> counter <= 0.
  - Mismatch and counter == FILT_LEN -> level <= s_last, counter <= 0.
  - Mismatch otherwise -> counter + 1.
  - FILT_LEN = 0 -> level follows s_last with one register delay.
- Latency: data_in sampled new at edge 0 -> level flips at edge SYNC_STAGES+FILT_LEN. Metastability may add one cycle.
- Glitch shorter than FILT_LEN+1 clk_fast cycles (post-sync) -> no level change, no pulse.
- edge_pulse: registered on the same edge that level updates. Asserted iff level changes and the direction matches mode (rise 0->1, fall 1->0). Width is exactly 1 cycle.
- mode = 00: level still tracks; no pulse, no pending.
- mode sampled combinationally at the edge of the level change; a mid-operation change affects only subsequent edges.
- pending:
  - edge_pulse -> 1.
  - clr -> 0.
  - Simultaneous edge_pulse & clr -> 1 (set wins).
- overflow:
  - edge_pulse & pending & ~clr -> 1.
  - clr -> 0.
  - Simultaneous edge_pulse & pending & clr -> overflow 0, pending 1.
- Channels fully independent; no cross-channel ordering guaranteed.
- Reset mid-filter: counter discarded, level = RST_VAL. A subsequent mismatch restarts the count from 0.

Decomposition:
- Package mesync_pkg: mode encodings MODE_OFF/MODE_RISE/MODE_FALL/MODE_BOTH (2-bit localparams) and function filt_cnt_w(FILT_LEN).
- Sub-module sync_filt_chan: one channel containing the sync chain, filter counter, level, edge qualify, pending and overflow. The top instantiates CH copies via generate and builds any_pending.

Test Plan:
- Reset release, data_in = 0, CH=4, SYNC=2, FILT=0 -> level = 0000, edge_pulse never asserts over 20 cycles.
- ch0 mode=01, data_in[0] 0->1 sampled at edge 0 -> level[0]=1 and edge_pulse[0]=1 after edge 2, pulse low after edge 3; pending[0]=1, any_pending=1.
- FILT_LEN=3: 2-cycle high glitch on ch1 -> no level change/pulse; 6-cycle high on ch1 -> level[1] rises after edge 5 (2+3).
- ch2 mode=11: toggle 0->1->0 with 10-cycle spacing -> two pulses, pending=1, overflow=1; clr[2] -> both 0 next cycle.
- ch3 edge_pulse coincident with clr[3] while pending[3]=1 -> pending stays 1, overflow stays 0.
- Assert rst mid-filter count (FILT=3, count=2) -> outputs clear immediately (async); after release, input held high -> level rises SYNC_STAGES+FILT_LEN cycles after first sampling edge.
